// File: rtl/line_buf_pkg.sv
// Shared defaults and counter-width helpers for the line-buffer window block.
package line_buf_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned IMG_W_DEF  = 220;
  localparam int unsigned KSIZE_DEF  = 5;

  // Width of a counter that must hold values 0..n-1; never below 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned COL_W_DEF = cnt_w(IMG_W_DEF);
  localparam int unsigned ROW_W_DEF = cnt_w(KSIZE_DEF);

endpackage

// File: rtl/lbuf_delay_line.sv
// One image-row delay: q is the sample entered DEPTH enables earlier; storage clears on reset.
module lbuf_delay_line #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 220
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (en) begin
      mem_q[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign q = mem_q[DEPTH-1];

endmodule

// File: rtl/line_buf_win.sv
// KSIZE-tap vertical line buffer with window-valid labelling.
// Define LINE_BUF_OUT_REG_EN to register tap_out/out_valid/win_valid (latency 1).
module line_buf_win
  import line_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned KSIZE  = KSIZE_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    sof,
  input  logic [DATA_W-1:0]       data_in,
  output logic [KSIZE*DATA_W-1:0] tap_out,
  output logic                    out_valid,
  output logic                    win_valid
);

  if (KSIZE < 2 || IMG_W < KSIZE) begin : g_param_check
    $error("line_buf_win: requires KSIZE >= 2 and IMG_W >= KSIZE");
  end

  localparam int unsigned COL_W = cnt_w(IMG_W);
  localparam int unsigned ROW_W = cnt_w(KSIZE);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_WIN  = COL_W'(KSIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(KSIZE - 1);

  logic [COL_W-1:0] col_q, col_d, col_lbl;
  logic [ROW_W-1:0] row_q, row_d, row_lbl;

  logic [DATA_W-1:0] chain [KSIZE];

  assign chain[0] = data_in;

  for (genvar g = 0; g < KSIZE - 1; g++) begin : g_line
    lbuf_delay_line #(
      .DATA_W(DATA_W),
      .DEPTH (IMG_W)
    ) u_line (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (in_valid),
      .d    (chain[g]),
      .q    (chain[g+1])
    );
  end

  // sof relabels the current pixel as (0,0) before the counters advance.
  always_comb begin
    col_lbl = col_q;
    row_lbl = row_q;
    if (in_valid && sof) begin
      col_lbl = '0;
      row_lbl = '0;
    end
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      col_d = (col_lbl == COL_LAST) ? '0 : col_lbl + 1'b1;
      row_d = (col_lbl == COL_LAST && row_lbl != ROW_LAST) ? row_lbl + 1'b1 : row_lbl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  logic [KSIZE*DATA_W-1:0] tap_c;
  logic                    ov_c;
  logic                    wv_c;

  // Tap 0 is the live input, so it is masked while reset is held.
  always_comb begin
    tap_c = '0;
    for (int unsigned i = 0; i < KSIZE; i++) tap_c[i*DATA_W +: DATA_W] = chain[i];
    if (!rst_n) tap_c = '0;
    ov_c = in_valid && rst_n;
    wv_c = ov_c && (row_lbl == ROW_LAST) && (col_lbl >= COL_WIN);
  end

`ifdef LINE_BUF_OUT_REG_EN
  logic [KSIZE*DATA_W-1:0] tap_q;
  logic                    ov_q;
  logic                    wv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q <= '0;
      ov_q  <= 1'b0;
      wv_q  <= 1'b0;
    end else begin
      tap_q <= tap_c;
      ov_q  <= ov_c;
      wv_q  <= wv_c;
    end
  end

  assign tap_out   = tap_q;
  assign out_valid = ov_q;
  assign win_valid = wv_q;
`else
  assign tap_out   = tap_c;
  assign out_valid = ov_c;
  assign win_valid = wv_c;
`endif

endmodule

// File: doc/line_buf_win.md
LINE_BUF_WIN -- requirements
Module: line_buf_win

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 220, pixels per image row.
REQ-003 The block SHALL have parameter KSIZE, default 5, kernel height and width; legal values are KSIZE >= 2 and IMG_W >= KSIZE.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: data_in carries an accepted pixel this cycle.
REQ-007 The block SHALL have port sof, input, 1 bit: start of frame; qualified by in_valid.
REQ-008 The block SHALL have port data_in, input, DATA_W bits: pixel in raster order.
REQ-009 The block SHALL have port tap_out, output, KSIZE*DATA_W bits: vertical column taps; tap i occupies [i*DATA_W +: DATA_W].
REQ-010 The block SHALL have port out_valid, output, 1 bit: tap_out corresponds to an accepted pixel.
REQ-011 The block SHALL have port win_valid, output, 1 bit: a full KSIZE x KSIZE window ends at this pixel.

Function
REQ-012 Tap 0 SHALL equal the current pixel, and tap i (1..KSIZE-1) SHALL equal the pixel accepted exactly i*IMG_W accepted pixels earlier, i.e. the same column i rows above.
REQ-013 The block SHALL build tap i from KSIZE-1 chained line delays of depth IMG_W, each advancing only when in_valid=1.
REQ-014 When in_valid=0, all delay contents and counters SHALL hold, and out_valid and win_valid SHALL be 0.
REQ-015 col_cnt (width $clog2(IMG_W)) SHALL increment per accepted pixel and wrap from IMG_W-1 to 0.
REQ-016 row_cnt SHALL increment on each col_cnt wrap and saturate at KSIZE-1.
REQ-017 The counters SHALL use the pre-update values to label the current pixel.
REQ-018 When sof=1 with in_valid=1, the current pixel SHALL be treated as col 0, row 0; after it, col_cnt=1 and row_cnt=0; delay contents SHALL NOT be cleared.
REQ-019 sof=1 with in_valid=0 SHALL be ignored.
REQ-020 win_valid SHALL be 1 exactly when in_valid=1, the current row label = KSIZE-1 (saturated), and the current col label >= KSIZE-1.
REQ-021 out_valid SHALL equal in_valid.
REQ-022 Default latency SHALL be 0 cycles: tap_out, out_valid and win_valid are combinational from the current inputs and registered state.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for a clock edge, force col_cnt=0, row_cnt=0, out_valid=0, win_valid=0, and tap_out=0 (taps 1..KSIZE-1 read 0 because the delay storage clears).
REQ-024 Reset SHALL be legal mid-row and mid-frame.
REQ-025 The first accepted pixel after reset SHALL be treated as row 0, col 0.

Configuration
REQ-026 When macro LINE_BUF_OUT_REG_EN is defined, tap_out, out_valid and win_valid SHALL be registered, giving latency 1 cycle; the registers reset to 0 and update every cycle, so out_valid/win_valid are 0 one cycle after an idle input.
REQ-027 When LINE_BUF_OUT_REG_EN is undefined, the block SHALL have latency 0 as in REQ-022, with no extra registers.

Structure
REQ-028 Package line_buf_pkg SHALL hold DATA_W_DEF=16, IMG_W_DEF=220, KSIZE_DEF=5 and the counter-width constant expressions.
REQ-029 Sub-module lbuf_delay_line SHALL implement the per-row delay: parameters DATA_W and DEPTH; ports clk, rst_n, en, d, q; q is the value entered DEPTH enables earlier; contents reset to 0.
REQ-030 line_buf_win SHALL instantiate lbuf_delay_line KSIZE-1 times in a generate loop.
REQ-031 Elaboration SHALL fail when KSIZE < 2 or IMG_W < KSIZE.

Verification (IMG_W=8, KSIZE=3, DATA_W=16; data value = accepted-pixel index)
REQ-032 Hold rst_n=0, toggle inputs -> tap_out=0, out_valid=0, win_valid=0 throughout.
REQ-033 Drive continuous ramp 0..23 with sof on pixel 0 -> win_valid first 1 at pixel 18 with taps {2,10,18}; win_valid=0 at pixels 16 and 17.
REQ-034 Drop in_valid for 5 cycles after pixel 12 -> out_valid=0 and state frozen; pixel 13 then yields taps {0,5,13}.
REQ-035 Assert sof on pixel 11 (row 1, col 3) -> counters restart; win_valid stays 0 until 2 rows plus 2 columns later.
REQ-036 Assert rst_n low asynchronously between edges at pixel 5 -> outputs 0 before the next edge; after release, pixel 0 is labelled row 0, col 0.
REQ-037 Rerun REQ-033 with LINE_BUF_OUT_REG_EN defined -> identical values delayed by exactly 1 cycle.
